frame_extract: RTL and testbench

FRAME_EXTRACT -- requirements
Module: frame_extract

---
 rtl/frame_extract_if.sv | 17 +
 rtl/frame_extract.sv | 176 +++++++++++++++++
 tb/tb_frame_extract.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_extract_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_extract_if
//  Purpose  : Payload output stream of frame_extract (data/last with
//             valid/ready handshake). master = producer, slave = consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface frame_extract_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       i_ready;

    modport master (output o_data, output o_valid, output o_last, input  i_ready);
    modport slave  (input  o_data, input  o_valid, input  o_last, output i_ready);
endinterface
`default_nettype wire

// File: rtl/frame_extract.sv
`default_nettype none
// ============================================================================
//  Module   : frame_extract
//  Purpose  : Extracts length-prefixed frames that follow a detected sync
//             word, buffers the payload speculatively and exposes a frame to
//             the consumer only once it has been fully received (and, in the
//             checksum build, verified).
//  Options  : FRAME_EXTRACT_CSUM_EN - append an XOR checksum byte after the
//             payload; frames whose checksum mismatches are discarded.
//  Revision : 1.0  initial release
// ============================================================================
module frame_extract #(
    parameter int DEPTH   = 32,
    parameter int MAX_LEN = 16
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    input  wire logic [7:0]  i_data,
    input  wire logic        i_detected,
    frame_extract_if.master  out_if,
    output logic             o_len_err,
    output logic             o_drop,
    output logic             o_busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
`ifdef FRAME_EXTRACT_CSUM_EN
    localparam logic [1:0] c_ST_CSUM    = 2'd2;
`endif

    logic [1:0]    r_state;
    logic [7:0]    r_cnt;          // payload bytes still to receive
    logic [AW-1:0] r_wr_ptr;       // speculative write pointer
    logic [AW-1:0] r_cm_ptr;       // committed write pointer
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cm_cnt;       // bytes visible to the consumer
    logic [AW:0]   r_spec_cnt;     // bytes written but not yet committed
    logic          r_commit_pend;  // commit happens in the cycle after the frame ends
    logic          r_len_err;
    logic          r_drop;
    logic [8:0]    r_mem [DEPTH];  // {last, data}
`ifdef FRAME_EXTRACT_CSUM_EN
    logic [7:0]    r_xor;
    logic          w_csum_fail;
`endif

    logic          w_wr_en;
    logic          w_last;
    logic          w_rd;
    logic          w_rewind;
    logic          w_len_ok;
    logic          w_no_room;
    logic [8:0]    w_head;

    assign w_wr_en   = (r_state == c_ST_PAYLOAD);
    assign w_last    = (r_cnt == 8'd1);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_rd      = out_if.o_valid && out_if.i_ready;
    assign w_len_ok  = (i_data != 8'd0) && (32'(i_data) <= 32'(MAX_LEN));
    // Free space counts uncommitted bytes as used; reads this cycle are not credited.
    assign w_no_room = (32'(DEPTH) - 32'(r_cm_cnt) - 32'(r_spec_cnt)) < 32'(i_data);

`ifdef FRAME_EXTRACT_CSUM_EN
    assign w_csum_fail = (r_state == c_ST_CSUM) && (i_data != r_xor);
    assign w_rewind    = w_csum_fail;
`else
    assign w_rewind    = 1'b0;
`endif

    // Only committed bytes are visible; data is forced to zero when idle.
    assign out_if.o_valid = (r_cm_cnt != '0);
    assign out_if.o_data  = out_if.o_valid ? w_head[7:0] : 8'd0;
    assign out_if.o_last  = out_if.o_valid ? w_head[8]   : 1'b0;
    assign o_len_err      = r_len_err;
    assign o_drop         = r_drop;
    assign o_busy         = (r_state != c_ST_IDLE);

    // Payload storage: one {last,data} entry per payload cycle.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {w_last, i_data};
        end
    end

    // Frame FSM, pointer management and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= 8'd0;
            r_wr_ptr      <= '0;
            r_cm_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_cm_cnt      <= '0;
            r_spec_cnt    <= '0;
            r_commit_pend <= 1'b0;
            r_len_err     <= 1'b0;
            r_drop        <= 1'b0;
`ifdef FRAME_EXTRACT_CSUM_EN
            r_xor         <= 8'd0;
`endif
        end else begin
            r_len_err     <= 1'b0;
            r_drop        <= 1'b0;
            r_commit_pend <= 1'b0;

            // Read side runs independently; commit and read may coincide.
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_cm_cnt <= r_cm_cnt + (r_commit_pend ? r_spec_cnt : '0)
                        - {{AW{1'b0}}, w_rd};

            if (r_commit_pend) begin
                r_cm_ptr   <= r_wr_ptr;
                r_spec_cnt <= '0;
            end else if (w_rewind) begin
                r_wr_ptr   <= r_cm_ptr;
                r_spec_cnt <= '0;
            end else if (w_wr_en) begin
                r_spec_cnt <= r_spec_cnt + 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (i_detected) begin
                        if (!w_len_ok) begin
                            r_len_err <= 1'b1;
                        end else if (w_no_room) begin
                            r_drop <= 1'b1;
                        end else begin
                            r_state <= c_ST_PAYLOAD;
                            r_cnt   <= i_data;
`ifdef FRAME_EXTRACT_CSUM_EN
                            r_xor   <= 8'd0;
`endif
                        end
                    end
                end
                c_ST_PAYLOAD: begin
                    // i_detected is deliberately ignored: payload may contain the sync word.
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_cnt    <= r_cnt - 8'd1;
`ifdef FRAME_EXTRACT_CSUM_EN
                    r_xor    <= r_xor ^ i_data;
                    if (w_last) begin
                        r_state <= c_ST_CSUM;
                    end
`else
                    if (w_last) begin
                        r_state       <= c_ST_IDLE;
                        r_commit_pend <= 1'b1;
                    end
`endif
                end
`ifdef FRAME_EXTRACT_CSUM_EN
                c_ST_CSUM: begin
                    r_state <= c_ST_IDLE;
                    if (w_csum_fail) begin
                        r_drop <= 1'b1;
                    end else begin
                        r_commit_pend <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_extract.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_extract
//  Purpose  : Scoreboard bench for frame_extract. Expected payload bytes are
//             queued as frames are sent; a monitor pops one per transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_extract;

    logic       clk;
    logic       rst;
    logic [7:0] i_data;
    logic       i_detected;
    logic       len_err;
    logic       drop;
    logic       busy;

    frame_extract_if ifc ();

    frame_extract #(.DEPTH(32), .MAX_LEN(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_data     (i_data),
        .i_detected (i_detected),
        .out_if     (ifc.master),
        .o_len_err  (len_err),
        .o_drop     (drop),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          n_len_err = 0;
    int          n_drop    = 0;
    logic [8:0]  sb_q [$];
    logic [7:0]  pay [0:31];
    logic        hold_prev = 1'b0;
    logic [8:0]  hold_val  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and counts status pulses.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (len_err) n_len_err++;
            if (drop)    n_drop++;
            if (hold_prev && ifc.o_valid)
                check("hold_stable", {23'd0, ifc.o_last, ifc.o_data}, {23'd0, hold_val});
            if (ifc.o_valid && ifc.i_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", {23'd0, ifc.o_last, ifc.o_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    check("out_byte", {23'd0, ifc.o_last, ifc.o_data}, {23'd0, e});
                end
            end
            hold_prev = ifc.o_valid && !ifc.i_ready;
            hold_val  = {ifc.o_last, ifc.o_data};
        end
    end

    task automatic drive(input logic det, input logic [7:0] b);
        i_detected = det;
        i_data     = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xor_of(input int len);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < len; i++) x = x ^ pay[i];
        return x;
    endfunction

    // Sends length byte, payload from pay[], and the checksum byte in the CSUM build.
    task automatic send_frame(input int len, input int det_at, input logic [7:0] csum, input bit expect_out);
        drive(1'b1, 8'(len));
        for (int i = 0; i < len; i++) begin
            if (expect_out) sb_q.push_back({(i == len - 1), pay[i]});
            drive(i == det_at, pay[i]);
        end
`ifdef FRAME_EXTRACT_CSUM_EN
        drive(1'b0, csum);
`else
        if (csum === 8'hxx) $display("note: checksum unused");
`endif
        i_detected = 1'b0;
        i_data     = 8'd0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_data = 8'd0;
        i_detected = 1'b0;
        ifc.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_valid",   ifc.o_valid, 0);
        check("rst_last",    ifc.o_last,  0);
        check("rst_data",    ifc.o_data,  0);
        check("rst_busy",    busy,        0);
        check("rst_len_err", len_err,     0);
        check("rst_drop",    drop,        0);

        // Basic frame 11 22 33 with latency check on an empty buffer
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(3, -1, xor_of(3), 1'b1);
        check("lat_not_yet", ifc.o_valid, 0);
        @(posedge clk); #1;
        check("lat_visible", ifc.o_valid, 1);
        check("lat_first",   ifc.o_data,  8'h11);
        wait_drain("drain_basic");

        // Illegal lengths 0 and 17
        drive(1'b1, 8'd0);
        check("len0_err",  len_err, 1);
        check("len0_busy", busy,    0);
        drive(1'b0, 8'd0);
        check("len0_pulse_end", len_err, 0);
        drive(1'b1, 8'd17);
        check("len17_err",  len_err, 1);
        check("len17_busy", busy,    0);
        drive(1'b0, 8'd0);
        check("len_err_valid", ifc.o_valid, 0);
        check("len_err_busy",  busy,        0);

`ifdef FRAME_EXTRACT_CSUM_EN
        // Checksum good then bad
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h04;
        send_frame(3, -1, 8'h07, 1'b1);
        wait_drain("drain_csum_ok");
        send_frame(3, -1, 8'h00, 1'b0);
        check("csum_bad_drop", drop, 1);
        repeat (4) drive(1'b0, 8'd0);
        check("csum_bad_empty", ifc.o_valid, 0);
`endif

        // Fill buffer with ready low, overflow frame dropped, then drain
        ifc.i_ready = 1'b0;
        for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
        send_frame(16, -1, xor_of(16), 1'b1);
        for (int i = 0; i < 16; i++) pay[i] = 8'(8'h80 + i);
        send_frame(16, -1, xor_of(16), 1'b1);
        drive(1'b0, 8'd0);
        drive(1'b1, 8'd1);
        check("full_drop", drop, 1);
        drive(1'b0, 8'd0);
        check("full_busy", busy, 0);
        repeat (3) drive(1'b0, 8'd0);
        ifc.i_ready = 1'b1;
        wait_drain("drain_full");

        // Payload containing sync word, i_detected pulsed mid-frame; back-to-back follow-up frame
        pay[0] = 8'h01; pay[1] = 8'h0A; pay[2] = 8'h0B; pay[3] = 8'h0C;
        pay[4] = 8'h0D; pay[5] = 8'h02; pay[6] = 8'h03; pay[7] = 8'h04;
        send_frame(8, 1, xor_of(8), 1'b1);
        pay[0] = 8'h55;
        send_frame(1, -1, xor_of(1), 1'b1);
        wait_drain("drain_sync");

        // Reset mid-frame discards buffered and partial frames
        ifc.i_ready = 1'b0;
        pay[0] = 8'hC1; pay[1] = 8'hC2;
        send_frame(2, -1, xor_of(2), 1'b0);
        drive(1'b0, 8'd0);
        drive(1'b1, 8'd5);
        drive(1'b0, 8'hE1);
        drive(1'b0, 8'hE2);
        rst = 1'b1;
        drive(1'b0, 8'hE3);
        rst = 1'b0;
        check("midrst_valid", ifc.o_valid, 0);
        check("midrst_busy",  busy,        0);
        ifc.i_ready = 1'b1;
        pay[0] = 8'hAA; pay[1] = 8'hBB;
        send_frame(2, -1, xor_of(2), 1'b1);
        wait_drain("drain_after_rst");
        repeat (3) drive(1'b0, 8'd0);

        check("len_err_pulses", n_len_err, 2);
`ifdef FRAME_EXTRACT_CSUM_EN
        check("drop_pulses", n_drop, 2);
`else
        check("drop_pulses", n_drop, 1);
`endif
        check("final_idle", ifc.o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
